// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioner.
// Mode and debounce-state encodings live here so channel and top agree.
package button_pkg;

  localparam int MODE_W  = 2;
  localparam int STATE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    PRESS   = 2'b00,
    RELEASE = 2'b01,
    BOTH    = 2'b10,
    REPEAT  = 2'b11
  } btn_mode_e;

  typedef enum logic [STATE_W-1:0] {
    RELEASED     = 2'b00,
    PRESS_PEND   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_PEND = 2'b11
  } btn_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: synchroniser, debounce FSM and auto-repeat timer.
// All outputs are registered single-cycle pulses plus a clean level.
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_raw,
  input  logic [1:0] i_mode,
  output logic       o_level,
  output logic       o_press,
  output logic       o_release,
  output logic       o_event
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW =
    $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [DW-1:0] D_LIM = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] D_ONE = DW'(1);
  localparam logic [RW-1:0] RD_LIM = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LIM = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] R_ONE = RW'(1);
  localparam logic IDLE = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] r_sync;
  btn_state_e             r_state;
  logic [DW-1:0]          r_cnt;
  logic [RW-1:0]          r_rcnt;
  logic                   r_rep_armed;

  btn_mode_e     w_mode;
  logic          w_s;
  logic          w_press_fire;
  logic          w_rel_fire;
  logic          w_rep_on;
  logic          w_rep_fire;
  logic [RW-1:0] w_rep_lim;

  assign w_mode = btn_mode_e'(i_mode);
  assign w_s    = r_sync[SYNC_STAGES-1] ^ IDLE;

  assign w_press_fire =
    (r_state == PRESS_PEND) && w_s && (r_cnt == D_LIM);
  assign w_rel_fire =
    (r_state == RELEASE_PEND) && !w_s && (r_cnt == D_LIM);

  // Repeat runs only while held in REPEAT mode; the first
  // interval is the long delay, later ones the short period.
  assign w_rep_on = (w_mode == REPEAT) &&
    ((r_state == PRESSED) || (r_state == RELEASE_PEND));
  assign w_rep_lim  = r_rep_armed ? RP_LIM : RD_LIM;
  assign w_rep_fire = w_rep_on && (r_rcnt == w_rep_lim);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync    <= {SYNC_STAGES{IDLE}};
      r_state   <= RELEASED;
      r_cnt     <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_event   <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_raw};
      o_press   <= w_press_fire;
      o_release <= w_rel_fire;
      unique case (w_mode)
        PRESS:   o_event <= w_press_fire;
        RELEASE: o_event <= w_rel_fire;
        BOTH:    o_event <= w_press_fire | w_rel_fire;
        REPEAT:  o_event <= w_press_fire | w_rep_fire;
      endcase
      unique case (r_state)
        RELEASED: begin
          if (w_s) begin
            r_state <= PRESS_PEND;
            r_cnt   <= D_ONE;
          end
        end
        PRESS_PEND: begin
          if (!w_s) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
          end else if (r_cnt == D_LIM) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
            o_level <= 1'b1;
          end else begin
            r_cnt <= r_cnt + D_ONE;
          end
        end
        PRESSED: begin
          if (!w_s) begin
            r_state <= RELEASE_PEND;
            r_cnt   <= D_ONE;
          end
        end
        RELEASE_PEND: begin
          if (w_s) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == D_LIM) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
            o_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + D_ONE;
          end
        end
        default: begin
          r_state <= RELEASED;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rcnt      <= '0;
      r_rep_armed <= 1'b0;
    end else if (!w_rep_on) begin
      r_rcnt      <= '0;
      r_rep_armed <= 1'b0;
    end else if (w_rep_fire) begin
      r_rcnt      <= '0;
      r_rep_armed <= 1'b1;
    end else begin
      r_rcnt <= r_rcnt + R_ONE;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button front end: one independent conditioner
// per pin, all sharing the run-time event mode.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw,
  input  logic [1:0]      mode,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_event
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    button_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_raw    (btn_raw[g]),
      .i_mode   (mode),
      .o_level  (btn_level[g]),
      .o_press  (btn_press[g]),
      .o_release(btn_release[g]),
      .o_event  (btn_event[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: stimulus queues expected pulses by cycle,
// a negedge monitor pops and compares whenever any pulse appears.
module tb_button_conditioner;

  typedef struct {
    int         cyc;
    logic [1:0] p;
    logic [1:0] r;
    logic [1:0] e;
    logic [1:0] l;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] btn_raw = 2'b11;
  logic [1:0] mode = 2'b00;
  logic [1:0] lvl;
  logic [1:0] prs;
  logic [1:0] rls;
  logic [1:0] evt;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   c0;
  exp_t q[$];
  exp_t mx;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_CH(2),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .mode(mode),
    .btn_level(lvl),
    .btn_press(prs),
    .btn_release(rls),
    .btn_event(evt)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [1:0] act,
                     input logic [1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b required %b (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  function automatic void push(input int at,
                               input logic [1:0] p,
                               input logic [1:0] r,
                               input logic [1:0] e,
                               input logic [1:0] l);
    exp_t x;
    x.cyc = at; x.p = p; x.r = r; x.e = e; x.l = l;
    q.push_back(x);
  endfunction

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      $display("FAIL missed_pulse: no pulse at cycle %0d, required one",
               q[0].cyc);
      void'(q.pop_front());
    end
    if (|{prs, rls, evt}) begin
      if (q.size() == 0 || q[0].cyc != cyc) begin
        checks++;
        $display("FAIL unexpected_pulse: p=%b r=%b e=%b at %0d, required none",
                 prs, rls, evt, cyc);
      end else begin
        mx = q.pop_front();
        chk("press", prs, mx.p);
        chk("release", rls, mx.r);
        chk("event", evt, mx.e);
        chk("level", lvl, mx.l);
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    wait_n(2);
    #1;
    chk("rst_level", lvl, 2'b00);
    chk("rst_press", prs, 2'b00);
    chk("rst_release", rls, 2'b00);
    chk("rst_event", evt, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    wait_n(20);
    chk("idle_level", lvl, 2'b00);

    // clean press, mode PRESS
    btn_raw[0] = 1'b0;
    push(cyc + 6, 2'b01, 2'b00, 2'b01, 2'b01);
    wait_n(10);
    chk("held_level", lvl, 2'b01);
    btn_raw[0] = 1'b1;
    push(cyc + 6, 2'b00, 2'b01, 2'b00, 2'b00);
    wait_n(10);

    // bouncy press
    btn_raw[0] = 1'b0; @(negedge clk);
    btn_raw[0] = 1'b1; @(negedge clk);
    btn_raw[0] = 1'b0; @(negedge clk);
    btn_raw[0] = 1'b1; @(negedge clk);
    btn_raw[0] = 1'b0;
    push(cyc + 6, 2'b01, 2'b00, 2'b01, 2'b01);
    wait_n(10);
    btn_raw[0] = 1'b1;
    push(cyc + 6, 2'b00, 2'b01, 2'b00, 2'b00);
    wait_n(10);

    // mode BOTH
    mode = 2'b10;
    btn_raw[0] = 1'b0;
    push(cyc + 6, 2'b01, 2'b00, 2'b01, 2'b01);
    wait_n(10);
    btn_raw[0] = 1'b1;
    push(cyc + 6, 2'b00, 2'b01, 2'b01, 2'b00);
    wait_n(10);

    // mode REPEAT on ch1, held 30 cycles past commit
    mode = 2'b11;
    btn_raw[1] = 1'b0;
    c0 = cyc + 6;
    push(c0, 2'b10, 2'b00, 2'b10, 2'b10);
    for (int k = 10; k <= 34; k += 3)
      push(c0 + k, 2'b00, 2'b00, 2'b10, 2'b10);
    wait_n(36);
    btn_raw[1] = 1'b1;
    push(cyc + 6, 2'b00, 2'b10, 2'b00, 2'b00);
    wait_n(15);

    // reset mid-debounce with ch1 committed
    mode = 2'b00;
    btn_raw[1] = 1'b0;
    push(cyc + 6, 2'b10, 2'b00, 2'b10, 2'b10);
    wait_n(10);
    btn_raw[0] = 1'b0;
    wait_n(4);
    rst = 1'b1;
    #1;
    chk("rst_mid_level", lvl, 2'b00);
    chk("rst_mid_press", prs, 2'b00);
    chk("rst_mid_event", evt, 2'b00);
    wait_n(2);
    rst = 1'b0;
    push(cyc + 6, 2'b11, 2'b00, 2'b11, 2'b11);
    wait_n(12);

    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL queue_drain: %0d pending, required 0", q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
